// File: rtl/max6951_receiver.sv
// Receive side of the MAX6951 3-wire write link: oversamples nCS/CKS/DTA, assembles
// 16-bit {addr, data} frames and keeps a shadow copy of the control and digit registers.
module max6951_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DI_nCS,
    input  logic        DI_CKS,
    input  logic        DI_DTA,
    output logic        busy,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_err,
    output logic        addr_err,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic [7:0]  config_reg,
    output logic [31:0] data_out,
    output logic [7:0]  dps_out
);

    // state   | meaning
    // RESYNC  | after reset: wait for a settled, deasserted nCS
    // IDLE    | waiting for nCS to fall
    // SHIFT   | frame in progress, shifting on CKS rises
    // COMMIT  | one cycle: validate the frame and update registers
    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    localparam int N_SYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N_SYNC-1:0] r_ncs_sync;
    logic [N_SYNC-1:0] r_cks_sync;
    logic [N_SYNC-1:0] r_dta_sync;
    logic              r_ncs_hist;
    logic              r_cks_hist;
    logic              r_dta_hist;
    logic              r_ncs_fall;
    logic              r_ncs_rise;
    logic              r_cks_rise;

    logic              w_ncs_s;
    logic              w_cks_s;
    logic              w_dta_s;

    assign w_ncs_s = r_ncs_sync[N_SYNC-1];
    assign w_cks_s = r_cks_sync[N_SYNC-1];
    assign w_dta_s = r_dta_sync[N_SYNC-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ncs_sync <= '1;
            r_cks_sync <= '0;
            r_dta_sync <= '0;
            r_ncs_hist <= 1'b1;
            r_cks_hist <= 1'b0;
            r_dta_hist <= 1'b0;
            r_ncs_fall <= 1'b0;
            r_ncs_rise <= 1'b0;
            r_cks_rise <= 1'b0;
        end else begin
            r_ncs_sync <= {r_ncs_sync[N_SYNC-2:0], DI_nCS};
            r_cks_sync <= {r_cks_sync[N_SYNC-2:0], DI_CKS};
            r_dta_sync <= {r_dta_sync[N_SYNC-2:0], DI_DTA};
            r_ncs_hist <= w_ncs_s;
            r_cks_hist <= w_cks_s;
            r_dta_hist <= w_dta_s;
            // Edges are registered; r_dta_hist is the data bit aligned with r_cks_rise.
            r_ncs_fall <= (w_ncs_s ^ r_ncs_hist) & ~w_ncs_s;
            r_ncs_rise <= (w_ncs_s ^ r_ncs_hist) & w_ncs_s;
            r_cks_rise <= (w_cks_s ^ r_cks_hist) & w_cks_s;
        end
    end

    state_t       r_state;
    logic         r_armed;
    logic [15:0]  r_shift;
    logic [4:0]   r_bit_cnt;
    logic         r_wr_valid;
    logic [7:0]   r_wr_addr;
    logic [7:0]   r_wr_data;
    logic         r_frame_err;
    logic         r_addr_err;
    logic [7:0]   r_decode_mode;
    logic [3:0]   r_intensity;
    logic [2:0]   r_scan_limit;
    logic [7:0]   r_config;
    logic [3:0]   r_dig_nib [8];
    logic [7:0]   r_dig_dp;

    logic [7:0]   w_addr;
    logic [7:0]   w_data;

    assign w_addr = r_shift[15:8];
    assign w_data = r_shift[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RESYNC;
            r_armed       <= 1'b0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_err   <= 1'b0;
            r_addr_err    <= 1'b0;
            r_decode_mode <= '0;
            r_intensity   <= '0;
            r_scan_limit  <= '0;
            r_config      <= '0;
            r_dig_dp      <= '0;
            for (int i = 0; i < 8; i++) begin
                r_dig_nib[i] <= '0;
            end
        end else begin
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_addr_err  <= 1'b0;
            case (r_state)
                ST_RESYNC: begin
                    // Skip the first cycle so the reset value of the chain is never trusted.
                    r_armed <= 1'b1;
                    if (r_armed && (&r_ncs_sync) && r_ncs_hist) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (r_ncs_fall) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_ncs_rise) begin
                        r_state <= ST_COMMIT;
                    end else if (r_cks_rise) begin
                        r_shift <= {r_shift[14:0], r_dta_hist};
                        if (r_bit_cnt != 5'd17) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    if (r_bit_cnt < 5'd16) begin
                        r_frame_err <= 1'b1;
                    end else begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= w_addr;
                        r_wr_data  <= w_data;
                        if (w_addr[7:3] == 5'b01100) begin
                            r_dig_nib[w_addr[2:0]] <= w_data[3:0];
                            r_dig_dp[w_addr[2:0]]  <= w_data[7];
                        end else begin
                            case (w_addr)
                                8'h00: ;
                                8'h01: r_decode_mode <= w_data;
                                8'h02: r_intensity   <= w_data[3:0];
                                8'h03: r_scan_limit  <= w_data[2:0];
                                8'h04: r_config      <= w_data;
                                default: r_addr_err  <= 1'b1;
                            endcase
                        end
                    end
                end
                default: r_state <= ST_RESYNC;
            endcase
        end
    end

    // Digit register 0x67 holds the least significant nibble and dp bit 0.
    always_comb begin
        data_out = '0;
        dps_out  = '0;
        for (int i = 0; i < 8; i++) begin
            data_out[4*i +: 4] = r_dig_nib[7-i];
            dps_out[i]         = r_dig_dp[7-i];
        end
    end

    assign busy        = (r_state == ST_SHIFT);
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_err   = r_frame_err;
    assign addr_err    = r_addr_err;
    assign decode_mode = r_decode_mode;
    assign intensity   = r_intensity;
    assign scan_limit  = r_scan_limit;
    assign config_reg  = r_config;

endmodule
